// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_arbiter
//  Description : Round-robin arbiter in front of a flip-flop register bank.
//                Each cycle at most one requester gets a single read or
//                write access. Read data is registered and appears in the
//                same cycle as the grant.
//
//  Ports       : clk      - clock, rising edge
//                reset_n  - synchronous active-low reset
//                req      - per-requester access request
//                we       - per-requester write enable (1 = write)
//                addr     - per-requester address, slice i*ADDR_W
//                wdata    - per-requester write data, slice i*DATA_W
//                lock     - per-requester bank hold (used only with
//                           ARB_LOCK_EN)
//                gnt      - registered one-hot grant
//                rvalid   - read data valid pulse
//                rdata    - read data
//                rd_id    - requester owning rdata
//                busy     - |gnt
//
//  Options     : define ARB_LOCK_EN to enable the LOCKED state, in which
//                the locking requester owns the bank until it releases it.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 8,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [ID_W-1:0]            rd_id,
    output logic                       busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_nxt;
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [ID_W-1:0]     win;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    logic [DATA_W-1:0]   bank [DEPTH];

`ifdef ARB_LOCK_EN
    logic [ID_W-1:0]     lock_id;
    logic [ID_W-1:0]     lock_id_nxt;
`else
    // lock is accepted but has no effect in this build
    logic unused_lock;
    assign unused_lock = &{1'b0, lock};
`endif

    assign busy = |gnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility, round-robin search and next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        eligible  = req;
        found     = 1'b0;
        win       = '0;
        gnt_nxt   = '0;
        ptr_nxt   = ptr;
        state_nxt = S_IDLE;
`ifdef ARB_LOCK_EN
        lock_id_nxt = lock_id;
`endif

        case (state)
`ifdef ARB_LOCK_EN
            // While the holder keeps requesting, nobody else is eligible.
            // Once it drops req the lock is gone and this very edge is
            // arbitrated normally.
            S_LOCKED: begin
                if (req[lock_id]) begin
                    eligible = NUM_REQ'(1) << lock_id;
                end else begin
                    eligible = req;
                end
            end
`endif
            default: eligible = req;
        endcase

        // Scan ptr, ptr+1, ..., wrapping modulo NUM_REQ; first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin : scan
            int              idx;
            logic [ID_W-1:0] idx_v;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = ID_W'(idx);
            if (!found && eligible[idx_v]) begin
                found = 1'b1;
                win   = idx_v;
            end
        end

        if (found) begin
            gnt_nxt   = NUM_REQ'(1) << win;
            ptr_nxt   = (win == LAST_ID) ? '0 : win + 1'b1;
            state_nxt = S_GRANT;
`ifdef ARB_LOCK_EN
            if (lock[win]) begin
                state_nxt   = S_LOCKED;
                lock_id_nxt = win;
            end
`endif
        end
    end

    assign win_addr  = addr[win*ADDR_W +: ADDR_W];
    assign win_wdata = wdata[win*DATA_W +: DATA_W];

    // ------------------------------------------------------------------
    // Grant, pointer, read port and storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt    <= '0;
            ptr    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rd_id  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            gnt    <= gnt_nxt;
            ptr    <= ptr_nxt;
            rvalid <= 1'b0;
            if (found) begin
                if (we[win]) begin
                    bank[win_addr] <= win_wdata;
                end else begin
                    rdata  <= bank[win_addr];
                    rd_id  <= win;
                    rvalid <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_id <= '0;
        end else begin
            lock_id <= lock_id_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_arbiter
//  Description : Directed self-checking bench for reg_bank_arbiter with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ID_W-1:0]           rd_id;
    logic                      busy;

    int tests_run = 0;
    int tests_failed = 0;

    reg_bank_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .lock    (lock),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rd_id   (rd_id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        we[i]                  = wr;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        lock    = '0;
        #1;

        // ---------------- Reset with everyone writing 0xFF ----------------
        req   = 4'b1111;
        we    = 4'b1111;
        wdata = {4{8'hFF}};
        tick();
        check("rst1_gnt",    32'(gnt),    32'h0);
        check("rst1_rvalid", 32'(rvalid), 32'h0);
        check("rst1_busy",   32'(busy),   32'h0);
        tick();
        check("rst2_gnt",    32'(gnt),    32'h0);
        check("rst2_rvalid", 32'(rvalid), 32'h0);
        check("rst2_rdata",  32'(rdata),  32'h0);

        reset_n = 1'b1;
        req     = 4'b0001;
        we      = '0;
        wdata   = '0;
        set_port(0, 1'b0, 3'd3, 8'h00);
        tick();
        check("rd3_gnt",    32'(gnt),    32'h1);
        check("rd3_rvalid", 32'(rvalid), 32'h1);
        check("rd3_rdata",  32'(rdata),  32'h00);
        check("rd3_busy",   32'(busy),   32'h1);
        req = '0;
        tick();

        // ---------------- Write then read ----------------
        // ptr is 1 here; requester 0 is the only one asking so it still wins
        req = 4'b0001;
        set_port(0, 1'b1, 3'd2, 8'hA5);
        tick();
        check("wr_gnt",    32'(gnt),    32'h1);
        check("wr_rvalid", 32'(rvalid), 32'h0);
        req = 4'b0100;
        set_port(2, 1'b0, 3'd2, 8'h00);
        tick();
        check("rd_gnt",    32'(gnt),    32'h4);
        check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rdata",  32'(rdata),  32'hA5);
        check("rd_id",     32'(rd_id),  32'h2);
        req = '0;
        tick();
        check("idle_gnt",    32'(gnt),    32'h0);
        check("idle_rvalid", 32'(rvalid), 32'h0);
        check("idle_rdata",  32'(rdata),  32'hA5);
        check("idle_rd_id",  32'(rd_id),  32'h2);

        // ---------------- Fairness ----------------
        do_reset();
        we   = '0;
        addr = '0;
        req  = 4'b1111;
        begin
            logic [3:0] exp_g [5];
            logic [1:0] exp_id [5];
            exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            for (int k = 0; k < 5; k++) begin
                tick();
                check($sformatf("fair_gnt%0d", k),   32'(gnt),   32'(exp_g[k]));
                check($sformatf("fair_rdid%0d", k),  32'(rd_id), 32'(exp_id[k]));
            end
        end

        // ---------------- Sparse requests ----------------
        do_reset();
        req = 4'b1010;
        begin
            logic [3:0] exp_s [3];
            exp_s = '{4'b0010, 4'b1000, 4'b0010};
            for (int k = 0; k < 3; k++) begin
                tick();
                check($sformatf("sparse_gnt%0d", k), 32'(gnt), 32'(exp_s[k]));
            end
        end
        req = '0;
        tick();
        check("sparse_end_gnt",  32'(gnt),  32'h0);
        check("sparse_end_busy", 32'(busy), 32'h0);

        // ---------------- Reset mid-access ----------------
        req = 4'b0010;
        set_port(1, 1'b1, 3'd5, 8'h77);
        tick();
        check("pre_wr_gnt", 32'(gnt), 32'h2);
        req = 4'b0010;
        set_port(1, 1'b0, 3'd5, 8'h00);
        tick();
        check("pre_rd_rdata", 32'(rdata), 32'h77);
        reset_n = 1'b0;
        req     = 4'b0010;
        set_port(1, 1'b1, 3'd5, 8'h3C);
        tick();
        check("midrst_gnt",    32'(gnt),    32'h0);
        check("midrst_rdata",  32'(rdata),  32'h0);
        reset_n = 1'b1;
        req     = '0;
        tick();
        req = 4'b0010;
        set_port(1, 1'b0, 3'd5, 8'h00);
        tick();
        check("post_rd_gnt",    32'(gnt),    32'h2);
        check("post_rd_rvalid", 32'(rvalid), 32'h1);
        check("post_rd_rdata",  32'(rdata),  32'h00);
        req = '0;
        tick();

        // ---------------- Lock ----------------
        do_reset();
        we   = '0;
        req  = 4'b0011;
        lock = 4'b0001;
`ifdef ARB_LOCK_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lock_gnt%0d", k), 32'(gnt), 32'h1);
        end
        lock = '0;
        tick();
        check("unlock_gnt0", 32'(gnt), 32'h1);
        tick();
        check("unlock_gnt1", 32'(gnt), 32'h2);
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("nolock_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
        end
`endif
        req  = '0;
        lock = '0;
        tick();
        check("final_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
